// File: rtl/dmi_pkg.sv
// Shared DMI definitions: op and response codes, default link widths, the
// request/response record layouts and the responder FSM state encoding.
// No ports; imported by dmi_regbank and dmi_reg_responder.
package dmi_pkg;

  localparam int unsigned DMI_ADDR_W = 32'd7;
  localparam int unsigned DMI_DATA_W = 32'd32;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED  = 2'd2;

  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [1:0]            op;
    logic [DMI_DATA_W-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [1:0]            resp;
    logic [DMI_DATA_W-1:0] data;
  } dmi_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmi_state_e;

endpackage

// File: rtl/dmi_regbank.sv
// Register bank behind the DMI responder. Register 0 is a read-only ID
// constant; registers 1..NUM_REGS-1 are read/write and clear on reset.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   addr         DMI address being serviced
//   we           write strobe (applied only when in range and not register 0)
//   wdata        write data
//   in_range     addr falls inside BASE_ADDR..BASE_ADDR+NUM_REGS-1
//   rdata        combinational read data (0 when out of range)
module dmi_regbank
  import dmi_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DMI_ADDR_W,
  parameter int unsigned       DATA_W    = DMI_DATA_W,
  parameter int unsigned       NUM_REGS  = 32'd16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 7'h04,
  parameter logic [DATA_W-1:0] ID_VALUE  = 32'h0DB6_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic              in_range,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned       IDX_W      = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic [ADDR_W-1:0] offset_s;
  logic [IDX_W-1:0]  idx_s;
  // Slot 0 is never written; it stays at its reset value and reads return ID_VALUE.
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // Address decode: offset wraps in ADDR_W bits, the >= test rejects wrapped values.
  always_comb begin
    offset_s = addr - BASE_ADDR;
    idx_s    = offset_s[IDX_W-1:0];
    in_range = (addr >= BASE_ADDR) && (offset_s < NUM_REGS_A);
  end

  // Read port.
  always_comb begin
    rdata = {DATA_W{1'b0}};
    if (!in_range) begin
      rdata = {DATA_W{1'b0}};
    end else if (idx_s == {IDX_W{1'b0}}) begin
      rdata = ID_VALUE;
    end else begin
      rdata = regs_q[idx_s];
    end
  end

  // Write port next-state; register 0 writes are silently dropped.
  always_comb begin
    regs_d = regs_q;
    if (we && in_range && (idx_s != {IDX_W{1'b0}})) begin
      regs_d[idx_s] = wdata;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 32'd0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/dmi_reg_responder.sv
// DMI responder endpoint: accepts one READ/WRITE/NOP request at a time,
// waits RESP_LATENCY cycles, executes against dmi_regbank on the edge that
// enters RESP, and holds a registered response until it is taken.
// Ports:
//   dmiClock, dmiReset            clock, asynchronous active-low reset
//   dmi_req_valid/ready           request handshake (ready high only in IDLE)
//   dmi_req_bits_addr/op/data     request payload, sampled on accept
//   dmi_resp_valid/ready          response handshake
//   dmi_resp_bits_resp/data       response code and read data
module dmi_reg_responder
  import dmi_pkg::*;
#(
  parameter int unsigned       ADDR_W       = DMI_ADDR_W,
  parameter int unsigned       DATA_W       = DMI_DATA_W,
  parameter int unsigned       NUM_REGS     = 32'd16,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 7'h04,
  parameter int unsigned       RESP_LATENCY = 32'd2,
  parameter logic [DATA_W-1:0] ID_VALUE     = 32'h0DB6_0001
) (
  input  logic              dmiClock,
  input  logic              dmiReset,
  input  logic              dmi_req_valid,
  output logic              dmi_req_ready,
  input  logic [ADDR_W-1:0] dmi_req_bits_addr,
  input  logic [1:0]        dmi_req_bits_op,
  input  logic [DATA_W-1:0] dmi_req_bits_data,
  output logic              dmi_resp_valid,
  input  logic              dmi_resp_ready,
  output logic [1:0]        dmi_resp_bits_resp,
  output logic [DATA_W-1:0] dmi_resp_bits_data
);

  localparam logic [3:0] LAT = 4'(RESP_LATENCY);

  dmi_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [1:0]        resp_q, resp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] cur_addr_s;
  logic [1:0]        cur_op_s;
  logic [DATA_W-1:0] cur_data_s;
  logic              exec_s, we_s, in_range_s;
  logic [DATA_W-1:0] bank_rdata_s;

  // Bank operands: live inputs in IDLE (zero-latency execute), captured copy otherwise.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_addr_s = dmi_req_bits_addr;
      cur_op_s   = dmi_req_bits_op;
      cur_data_s = dmi_req_bits_data;
    end else begin
      cur_addr_s = addr_q;
      cur_op_s   = op_q;
      cur_data_s = wdata_q;
    end
  end

  dmi_regbank #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .BASE_ADDR(BASE_ADDR),
    .ID_VALUE (ID_VALUE)
  ) u_regbank (
    .clk     (dmiClock),
    .rst_n   (dmiReset),
    .addr    (cur_addr_s),
    .we      (we_s),
    .wdata   (cur_data_s),
    .in_range(in_range_s),
    .rdata   (bank_rdata_s)
  );

  // FSM next state, capture, latency counter and response formation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    op_d         = op_q;
    wdata_d      = wdata_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    rdata_d      = rdata_q;
    exec_s       = 1'b0;
    we_s         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dmi_req_valid && req_ready_q) begin
          addr_d      = dmi_req_bits_addr;
          op_d        = dmi_req_bits_op;
          wdata_d     = dmi_req_bits_data;
          req_ready_d = 1'b0;
          if (LAT == 4'd0) begin
            exec_s  = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = LAT;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          exec_s  = 1'b1;
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        // req_ready rises only after the response handshake, never alongside it.
        if (dmi_resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          resp_d       = DMI_RESP_SUCCESS;
          rdata_d      = {DATA_W{1'b0}};
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        cnt_d        = 4'd0;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        resp_d       = DMI_RESP_SUCCESS;
        rdata_d      = {DATA_W{1'b0}};
      end
    endcase

    if (exec_s) begin
      resp_valid_d = 1'b1;
      rdata_d      = {DATA_W{1'b0}};
      case (cur_op_s)
        DMI_OP_NOP: begin
          resp_d = DMI_RESP_SUCCESS;
        end
        DMI_OP_READ: begin
          if (in_range_s) begin
            resp_d  = DMI_RESP_SUCCESS;
            rdata_d = bank_rdata_s;
          end else begin
            resp_d = DMI_RESP_FAILED;
          end
        end
        DMI_OP_WRITE: begin
          if (in_range_s) begin
            resp_d = DMI_RESP_SUCCESS;
            we_s   = 1'b1;
          end else begin
            resp_d = DMI_RESP_FAILED;
          end
        end
        default: begin
          resp_d = DMI_RESP_FAILED;
        end
      endcase
    end else begin
      we_s = 1'b0;
    end
  end

  // FSM, capture and response registers.
  always_ff @(posedge dmiClock or negedge dmiReset) begin
    if (!dmiReset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= {ADDR_W{1'b0}};
      op_q         <= DMI_OP_NOP;
      wdata_q      <= {DATA_W{1'b0}};
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_q       <= DMI_RESP_SUCCESS;
      rdata_q      <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      rdata_q      <= rdata_d;
    end
  end

  assign dmi_req_ready      = req_ready_q;
  assign dmi_resp_valid     = resp_valid_q;
  assign dmi_resp_bits_resp = resp_q;
  assign dmi_resp_bits_data = rdata_q;

endmodule

// File: tb/tb_dmi_reg_responder.sv
// Scoreboard bench for dmi_reg_responder: the driver computes each expected
// response from a register-array model and queues it at accept time; the
// monitor compares whatever the DUT presents against the queue head.
module tb_dmi_reg_responder;

  localparam int          LAT   = 2;
  localparam int          BASE  = 4;
  localparam int          NREGS = 16;
  localparam logic [31:0] ID    = 32'h0DB6_0001;

  logic        dmiClock = 1'b0;
  logic        dmiReset;
  logic        dmi_req_valid;
  logic        dmi_req_ready;
  logic [6:0]  dmi_req_bits_addr;
  logic [1:0]  dmi_req_bits_op;
  logic [31:0] dmi_req_bits_data;
  logic        dmi_resp_valid;
  logic        dmi_resp_ready = 1'b0;
  logic [1:0]  dmi_resp_bits_resp;
  logic [31:0] dmi_resp_bits_data;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_regs [NREGS];
  int          cyc = 0;
  bit          hold;
  bit          done;
  bit          timed_out;
  int          n_checks = 0;
  int          n_fail = 0;

  dmi_reg_responder dut (
    .dmiClock          (dmiClock),
    .dmiReset          (dmiReset),
    .dmi_req_valid     (dmi_req_valid),
    .dmi_req_ready     (dmi_req_ready),
    .dmi_req_bits_addr (dmi_req_bits_addr),
    .dmi_req_bits_op   (dmi_req_bits_op),
    .dmi_req_bits_data (dmi_req_bits_data),
    .dmi_resp_valid    (dmi_resp_valid),
    .dmi_resp_ready    (dmi_resp_ready),
    .dmi_resp_bits_resp(dmi_resp_bits_resp),
    .dmi_resp_bits_data(dmi_resp_bits_data)
  );

  always #5 dmiClock = ~dmiClock;

  always @(posedge dmiClock) cyc <= cyc + 1;

  // Reference behaviour of one transaction; updates the model bank.
  function automatic void model_txn(input logic [1:0] op, input logic [6:0] addr,
                                    input logic [31:0] data,
                                    output logic [1:0] r, output logic [31:0] d);
    int a;
    int idx;
    bit inr;
    a   = int'(addr);
    idx = a - BASE;
    inr = (a >= BASE) && (idx < NREGS);
    r   = 2'd0;
    d   = 32'd0;
    case (op)
      2'd0: r = 2'd0;
      2'd1: if (inr) d = (idx == 0) ? ID : model_regs[idx]; else r = 2'd2;
      2'd2: if (inr) begin if (idx != 0) model_regs[idx] = data; end else r = 2'd2;
      default: r = 2'd2;
    endcase
  endfunction

  task automatic send(input logic [1:0] op, input logic [6:0] addr,
                      input logic [31:0] data, input bit expect_resp);
    int   g;
    exp_t e;
    @(negedge dmiClock);
    dmi_req_valid     = 1'b1;
    dmi_req_bits_op   = op;
    dmi_req_bits_addr = addr;
    dmi_req_bits_data = data;
    g = 0;
    while (!dmi_req_ready && g < 100) begin
      @(negedge dmiClock);
      g++;
    end
    if (!dmi_req_ready) begin
      timed_out     = 1'b1;
      dmi_req_valid = 1'b0;
    end else begin
      if (expect_resp) begin
        model_txn(op, addr, data, e.resp, e.data);
        e.due = cyc + LAT + 1;
        sb.push_back(e);
      end
      @(posedge dmiClock);
      #1;
      // Scramble payload so late sampling of the inputs would be visible.
      dmi_req_valid     = 1'b0;
      dmi_req_bits_op   = 2'($urandom_range(0, 3));
      dmi_req_bits_addr = 7'($urandom_range(0, 127));
      dmi_req_bits_data = $urandom;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge dmiClock);
      g++;
    end
    if (sb.size() != 0) timed_out = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: all comparisons and the response-side handshake live here.
  initial begin
    bit prev_pend;
    bit prev_hs;
    bit hs;
    prev_pend = 1'b0;
    prev_hs   = 1'b0;
    forever begin
      @(negedge dmiClock);
      if (done) begin
        check("drv_timeout", 32'(timed_out), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end else if (!dmiReset) begin
        check("rst_req_ready", 32'(dmi_req_ready), 32'd1);
        check("rst_resp_valid", 32'(dmi_resp_valid), 32'd0);
        check("rst_resp", 32'(dmi_resp_bits_resp), 32'd0);
        check("rst_data", dmi_resp_bits_data, 32'd0);
        dmi_resp_ready = 1'b0;
        prev_pend      = 1'b0;
        prev_hs        = 1'b0;
      end else begin
        if (prev_hs) begin
          check("ready_after_hs", 32'(dmi_req_ready), 32'd1);
          check("valid_drop", 32'(dmi_resp_valid), 32'd0);
        end
        if (dmi_resp_valid) begin
          check("req_ready_low", 32'(dmi_req_ready), 32'd0);
          if (sb.size() == 0) begin
            check("spurious_resp", 32'(sb.size()), 32'd1);
          end else begin
            if (!prev_pend) check("latency", 32'(cyc), 32'(sb[0].due));
            check("resp", 32'(dmi_resp_bits_resp), 32'(sb[0].resp));
            check("data", dmi_resp_bits_data, sb[0].data);
          end
        end
        dmi_resp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        hs = dmi_resp_valid && dmi_resp_ready;
        if (hs && sb.size() != 0) void'(sb.pop_front());
        prev_pend = dmi_resp_valid && !hs;
        prev_hs   = hs;
      end
    end
  end

  // Driver / stimulus sequence.
  initial begin
    int g;
    dmiReset          = 1'b0;
    dmi_req_valid     = 1'b0;
    dmi_req_bits_addr = 7'd0;
    dmi_req_bits_op   = 2'd0;
    dmi_req_bits_data = 32'd0;
    hold              = 1'b0;
    done              = 1'b0;
    timed_out         = 1'b0;
    for (int i = 0; i < NREGS; i++) model_regs[i] = 32'd0;
    repeat (3) @(negedge dmiClock);
    @(posedge dmiClock);
    #1 dmiReset = 1'b1;

    // Directed: ID read, write/readback, boundaries, failures, NOP.
    send(2'd1, 7'h04, 32'd0, 1'b1);
    send(2'd2, 7'h06, 32'hCAFE_F00D, 1'b1);
    send(2'd1, 7'h06, 32'd0, 1'b1);
    send(2'd1, 7'h05, 32'd0, 1'b1);
    send(2'd1, 7'h03, 32'd0, 1'b1);
    send(2'd1, 7'h14, 32'd0, 1'b1);
    send(2'd3, 7'h05, 32'h1234_5678, 1'b1);
    send(2'd0, 7'h06, 32'hFFFF_FFFF, 1'b1);
    send(2'd2, 7'h04, 32'hDEAD_BEEF, 1'b1);
    send(2'd1, 7'h04, 32'd0, 1'b1);
    send(2'd2, 7'h13, 32'hA5A5_5A5A, 1'b1);
    send(2'd1, 7'h13, 32'd0, 1'b1);
    send(2'd2, 7'h14, 32'h0BAD_0BAD, 1'b1);
    send(2'd1, 7'h06, 32'd0, 1'b1);
    drain();

    // Response backpressure for 10 cycles.
    hold = 1'b1;
    send(2'd1, 7'h06, 32'd0, 1'b1);
    g = 0;
    while (!dmi_resp_valid && g < 50) begin
      @(negedge dmiClock);
      g++;
    end
    if (!dmi_resp_valid) timed_out = 1'b1;
    repeat (10) @(negedge dmiClock);
    hold = 1'b0;
    drain();

    // Reset while a write waits: no response, write never lands.
    send(2'd2, 7'h07, 32'h7777_7777, 1'b0);
    dmiReset = 1'b0;
    for (int i = 0; i < NREGS; i++) model_regs[i] = 32'd0;
    repeat (3) @(posedge dmiClock);
    #1 dmiReset = 1'b1;
    send(2'd1, 7'h07, 32'd0, 1'b1);
    send(2'd1, 7'h06, 32'd0, 1'b1);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(4, 19)) : 7'($urandom_range(0, 127));
      send(2'($urandom_range(0, 3)), a, $urandom, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge dmiClock);
    end
    drain();
    done = 1'b1;
  end

endmodule
